// File: rtl/elevator_request_latch.sv
// -----------------------------------------------------------------------------
// elevator_request_latch
//
// Purpose:
//   Latches floor-call button presses into a 5-bit pending-request register
//   that drives the request inputs of the downstream elevator controller.
//   A request for floor i is set on a press of button i. It is cleared when
//   the controller reports arrival at floor i. The block does not prioritise
//   or reorder requests.
//
// Configuration:
//   DEBOUNCE_EN (macro) - when defined, a press is accepted only after
//                         DB_CYCLES consecutive high samples, using a 4-bit
//                         saturating counter per button. When undefined,
//                         a press is a plain rising edge and no counters exist.
//   DB_CYCLES (param)   - debounce length, legal range 2..15.
//
// Ports:
//   clk                       single clock, all state on its rising edge
//   rst                       synchronous active-high reset
//   bgnd,b1st,b2nd,b3rd,b4th  raw floor-call buttons (clk-synchronous levels)
//   floor[2:0]                current floor, 0..4 valid, 5..7 ignored
//   arrived                   one-cycle strobe: car stopped at floor
//   rgnd,r1st,r2nd,r3rd,r4th  registered pending-request bits
//   pending                   OR of the request bits
//   req_count[2:0]            number of pending requests, 0..5
// -----------------------------------------------------------------------------
module elevator_request_latch #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bgnd,
  input  logic       b1st,
  input  logic       b2nd,
  input  logic       b3rd,
  input  logic       b4th,
  input  logic [2:0] floor,
  input  logic       arrived,
  output logic       rgnd,
  output logic       r1st,
  output logic       r2nd,
  output logic       r3rd,
  output logic       r4th,
  output logic       pending,
  output logic [2:0] req_count
);

  // Reject an illegal debounce length at elaboration.
  if (DB_CYCLES < 2 || DB_CYCLES > 15) begin : g_bad_db_cycles
    $error("elevator_request_latch: DB_CYCLES must be in 2..15");
  end

  logic [4:0] btn;      // bit i = button for floor i, bit 0 = ground
  logic [4:0] req_q;    // pending requests
  logic [4:0] req_d;
  logic [4:0] prev_q;   // previous sample, or "held since reset" flag
  logic [4:0] prev_d;
  logic [4:0] press;    // accepted presses at this edge
  logic [4:0] clr;      // one-hot clear from an arrival

  assign btn = {b4th, b3rd, b2nd, b1st, bgnd};

  // Arrival at an invalid floor (5..7) decodes to no clear at all.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    clr = '0;
    if (arrived && (floor <= 3'd4)) begin
      clr[floor] = 1'b1;
    end
  end

`ifdef DEBOUNCE_EN
  localparam logic [3:0] DB_ACCEPT = 4'(DB_CYCLES - 1);

  logic [3:0] cnt_q [5];
  logic [3:0] cnt_d [5];

  // The counter saturates at 15 and DB_CYCLES <= 15, so the counter passes
  // through DB_CYCLES exactly once per high period. prev_q marks a button
  // held through reset. Such a button is ignored until it reads low once.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      cnt_d[i]  = cnt_q[i];
      press[i]  = 1'b0;
      prev_d[i] = prev_q[i] & btn[i];
      if (!btn[i]) begin
        cnt_d[i] = '0;
      end else begin
        if (cnt_q[i] != 4'hF) begin
          cnt_d[i] = cnt_q[i] + 4'd1;
        end
        press[i] = (cnt_q[i] == DB_ACCEPT) && !prev_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the counter array is control state, not storage. Each entry is
    // reset explicitly, so no button can inherit a stale partial count.
    if (rst) begin
      for (int i = 0; i < 5; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 5; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end
`else
  // A press is a low-to-high transition between consecutive samples.
  always_comb begin
    press  = btn & ~prev_q;
    prev_d = btn;
  end
`endif

  // A clear wins over a press on the same floor. Other floors are independent.
  always_comb begin
    req_d = (req_q | press) & ~clr;
  end

  // prev_q loads the live buttons during reset. A button held through reset
  // therefore looks "already seen" and cannot latch until it is re-pressed.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so all flops
    // sample their inputs from the same instant of the edge.
    if (rst) begin
      req_q  <= '0;
      prev_q <= btn;
    end else begin
      req_q  <= req_d;
      prev_q <= prev_d;
    end
  end

  // Status is decoded straight from the register, so it never lags R.
  always_comb begin
    req_count = '0;
    for (int i = 0; i < 5; i++) begin
      req_count = req_count + {2'b00, req_q[i]};
    end
    pending = |req_q;
  end

  assign rgnd = req_q[0];
  assign r1st = req_q[1];
  assign r2nd = req_q[2];
  assign r3rd = req_q[3];
  assign r4th = req_q[4];

endmodule

// File: tb/tb_elevator_request_latch.sv
// -----------------------------------------------------------------------------
// tb_elevator_request_latch
//
// Bench for the default build of elevator_request_latch (DEBOUNCE_EN
// undefined). Each cycle the stimulus is driven on the falling edge. A
// behavioural model computes the expected register state after the next
// rising edge and pushes it to a scoreboard queue. The entry is popped and
// compared 1 time unit after that rising edge. The bench also compares
// fixed values at the points of interest in each scenario.
// -----------------------------------------------------------------------------
module tb_elevator_request_latch;

  typedef struct packed {
    logic [4:0] r;
    logic       pend;
    logic [2:0] cnt;
  } expect_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       bgnd, b1st, b2nd, b3rd, b4th;
  logic [2:0] floor;
  logic       arrived;
  logic       rgnd, r1st, r2nd, r3rd, r4th;
  logic       pending;
  logic [2:0] req_count;

  int n_checks = 0;
  int n_fail   = 0;

  expect_t    sb_q[$];
  logic [4:0] m_r;   // model request register
  logic [4:0] m_p;   // model previous button sample
  logic [4:0] btn_v; // currently driven buttons

  elevator_request_latch #(.DB_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bgnd      (bgnd),
    .b1st      (b1st),
    .b2nd      (b2nd),
    .b3rd      (b3rd),
    .b4th      (b4th),
    .floor     (floor),
    .arrived   (arrived),
    .rgnd      (rgnd),
    .r1st      (r1st),
    .r2nd      (r2nd),
    .r3rd      (r3rd),
    .r4th      (r4th),
    .pending   (pending),
    .req_count (req_count)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] dut_r();
    return {r4th, r3rd, r2nd, r1st, rgnd};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus and advance the model. Push the expectation,
  // then pop and compare it after the edge.
  task automatic step(input logic [4:0] b, input logic arr, input logic [2:0] fl,
                      input logic rs);
    expect_t e;
    logic [4:0] rise;
    @(negedge clk);
    {b4th, b3rd, b2nd, b1st, bgnd} = b;
    arrived = arr;
    floor   = fl;
    rst     = rs;
    btn_v   = b;
    if (rs) begin
      m_r = '0;
      m_p = b;
    end else begin
      rise = b & ~m_p;
      m_p  = b;
      for (int i = 0; i < 5; i++) begin
        if (arr && (fl == 3'(i))) m_r[i] = 1'b0;
        else if (rise[i])         m_r[i] = 1'b1;
      end
    end
    e.r    = m_r;
    e.pend = |m_r;
    e.cnt  = 3'($countones(m_r));
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("sb_r",       32'(dut_r()),   32'(e.r));
    check("sb_pending", 32'(pending),   32'(e.pend));
    check("sb_count",   32'(req_count), 32'(e.cnt));
  endtask

  task automatic idle(input logic [4:0] b, input int n);
    for (int i = 0; i < n; i++) step(b, 1'b0, 3'd0, 1'b0);
  endtask

  initial begin
    {b4th, b3rd, b2nd, b1st, bgnd} = '0;
    arrived = 1'b0;
    floor   = 3'd0;
    rst     = 1'b1;
    m_r     = '0;
    m_p     = '0;
    btn_v   = '0;

    // Reset, then idle for edges 1..2.
    step(5'b00000, 1'b0, 3'd0, 1'b1);
    check("reset_r",     32'(dut_r()),   32'h0);
    check("reset_count", 32'(req_count), 32'h0);
    check("reset_pend",  32'(pending),   32'h0);
    idle(5'b00000, 1);

    // b2nd rises at edge 3 and is then held for 20 cycles: one request only.
    step(5'b00100, 1'b0, 3'd0, 1'b0);
    check("press_r2nd",  32'(r2nd),      32'h1);
    check("press_count", 32'(req_count), 32'h1);
    idle(5'b00100, 20);
    check("hold_count",  32'(req_count), 32'h1);

    // A held button cleared by an arrival must not re-set the request.
    step(5'b00100, 1'b1, 3'd2, 1'b0);
    idle(5'b00100, 3);
    check("held_after_clear", 32'(dut_r()), 32'h00);

    // b1st and b3rd rise together, then the car arrives at floor 3.
    step(5'b01010, 1'b0, 3'd0, 1'b0);
    check("dual_press", 32'(dut_r()), 32'h0A);
    step(5'b00000, 1'b1, 3'd3, 1'b0);
    check("clear3_r",     32'(dut_r()),   32'h02);
    check("clear3_count", 32'(req_count), 32'h1);
    step(5'b00000, 1'b1, 3'd1, 1'b0);

    // A press and a clear on the same floor at the same edge: the clear wins.
    step(5'b10000, 1'b1, 3'd4, 1'b0);
    check("clear_wins", 32'(r4th), 32'h0);
    idle(5'b00000, 1);
    // Presses on ground and floor 2 while floor 4 is cleared.
    step(5'b00101, 1'b1, 3'd4, 1'b0);
    check("press_vs_clear", 32'(dut_r()), 32'h05);

    // Build R = 10101, then arrive at invalid floor 6.
    step(5'b10101, 1'b0, 3'd0, 1'b0);
    step(5'b10101, 1'b1, 3'd6, 1'b0);
    check("bad_floor_r",     32'(dut_r()),   32'h15);
    check("bad_floor_count", 32'(req_count), 32'h3);

    // Re-pressing an already-pending floor leaves R unchanged.
    idle(5'b00000, 1);
    step(5'b00001, 1'b0, 3'd0, 1'b0);
    check("repress", 32'(dut_r()), 32'h15);

    // A press on floor 1 while floor 0 is cleared: both take effect.
    step(5'b00010, 1'b1, 3'd0, 1'b0);
    check("press1_clear0", 32'(dut_r()), 32'h16);

    // All five pending, then reset for one edge with bgnd held throughout.
    idle(5'b00000, 1);
    step(5'b11111, 1'b0, 3'd0, 1'b0);
    check("all_pending", 32'(req_count), 32'h5);
    step(5'b00001, 1'b0, 3'd0, 1'b0);
    step(5'b00001, 1'b0, 3'd0, 1'b1);
    check("mid_reset_r",     32'(dut_r()),   32'h0);
    check("mid_reset_count", 32'(req_count), 32'h0);
    idle(5'b00001, 5);
    check("held_thru_reset", 32'(rgnd), 32'h0);
    idle(5'b00000, 1);
    step(5'b00001, 1'b0, 3'd0, 1'b0);
    check("repress_after_reset", 32'(rgnd), 32'h1);

    // Random traffic against the model, with an occasional reset.
    for (int i = 0; i < 300; i++) begin
      step(5'($urandom_range(0, 31)),
           ($urandom_range(0, 3) == 0),
           3'($urandom_range(0, 7)),
           ($urandom_range(0, 40) == 0));
    end

    check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/elevator_request_latch.md
ELEVATOR_REQUEST_LATCH -- requirements
Module: elevator_request_latch

Interface
REQ-001 Parameter: DB_CYCLES, 4, consecutive high samples needed to accept a press when DEBOUNCE_EN is defined; legal range 2..15.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 bgnd, b1st, b2nd, b3rd, b4th  input  1 each  raw floor-call buttons, level, asynchronous to nothing (already clk-synchronous).
REQ-005 floor  input  3  current floor from the downstream elevator_4stage controller, 0..4; 5..7 invalid.
REQ-006 arrived  input  1  one-cycle strobe from the controller: car stopped at floor.
REQ-007 rgnd, r1st, r2nd, r3rd, r4th  output  1 each  registered pending-request levels, driving the controller's request inputs directly.
REQ-008 pending  output  1  OR of the five request bits.
REQ-009 req_count  output  3  number of pending requests, 0..5.

Function
REQ-010 Block SHALL hold a 5-bit request register R, bit i = floor i, bit 0 = ground; outputs r* SHALL be R directly.
REQ-011 Each button SHALL have a registered previous-sample bit P; a press on floor i SHALL be detected at edge k when button i = 1 at edge k and P_i = 0.
REQ-012 Without DEBOUNCE_EN, a detected press SHALL set R_i at the same edge k, so r_i is high from edge k onward.
REQ-013 A held button SHALL set R_i at most once per low-to-high transition; holding it after R_i is cleared SHALL NOT re-set R_i.
REQ-014 Press on a floor whose R_i is already 1 SHALL leave R unchanged.
REQ-015 At an edge with arrived = 1 and floor = i (0..4), R_i SHALL be cleared.
REQ-016 arrived = 1 with floor 5..7 SHALL clear nothing and SHALL NOT disturb other state.
REQ-017 Simultaneous press and clear on the same floor at the same edge: clear SHALL win, R_i = 0.
REQ-018 Simultaneous press on floor j and clear on floor i (i != j): both SHALL take effect at that edge.
REQ-019 Multiple buttons pressed at the same edge SHALL all be latched at that edge.
REQ-020 pending and req_count SHALL be combinational functions of R only, so they update with R and never lag it.
REQ-021 Block SHALL NOT prioritise or reorder requests; target selection belongs to the controller.

Reset
REQ-022 While rst = 1 at an edge: R = 0, debounce counters = 0, and P SHALL load the current button values.
REQ-023 Consequence of REQ-022: a button held through reset SHALL NOT latch after reset release until released and pressed again.
REQ-024 Reset outputs: r* = 0, pending = 0, req_count = 0; reset mid-operation SHALL discard all pending requests at that edge.
REQ-025 rst SHALL take priority over press, clear and debounce activity.

Configuration
REQ-026 Macro DEBOUNCE_EN: when defined, each button SHALL have a 4-bit saturating counter incremented on every high sample and zeroed on any low sample; a press SHALL be accepted, and R_i set, at the edge where the counter reaches DB_CYCLES, once per high period.
REQ-027 With DEBOUNCE_EN defined, a high pulse shorter than DB_CYCLES samples SHALL be ignored, and P-based edge detection (REQ-011) SHALL be replaced by the counter.
REQ-028 Without DEBOUNCE_EN, no counters SHALL be synthesised and REQ-012 latency (zero cycles after the sampling edge) SHALL apply.

Verification
REQ-029 Reset, then b2nd high at edge 3 -> r2nd = 1 from edge 3, pending = 1, req_count = 1; hold b2nd 20 cycles -> still one request, count 1.
REQ-030 Press b1st and b3rd at the same edge, then arrived = 1 with floor = 3 -> r3rd = 0, r1st = 1, req_count = 1.
REQ-031 b4th rising and arrived = 1 with floor = 4 at the same edge -> r4th stays 0; b0/b2 pressed while clearing floor 4 -> r4th = 0, rgnd = r2nd = 1.
REQ-032 arrived = 1 with floor = 6 while R = 5'b10101 -> R unchanged, req_count = 3.
REQ-033 All five buttons pending, rst = 1 for one edge with bgnd held -> all r* = 0, req_count = 0; bgnd held afterwards -> rgnd stays 0 until released and re-pressed.
REQ-034 DEBOUNCE_EN, DB_CYCLES = 4: b3rd high 3 cycles -> no request; high 4 cycles -> r3rd = 1 at the 4th high sample edge.
